// File: rtl/bus_pkg.sv
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared types and helpers for the CPU-side bus controller:
//                FSM state enum, decoded access target and the IO channel
//                base address calculation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_pkg;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } bus_state_t;

    // Decoded access target. The widths cover the largest supported
    // configuration (8 channels, 8-bit register index); users slice down.
    typedef struct packed {
        logic       isIo;
        logic [2:0] channel;
        logic [7:0] regSel;
    } target_t;

    // Base address of IO channel c. The channels are packed against the
    // top of the address space, channel NUM_IO-1 ending at the last address.
    function automatic int io_base(input int addr_w, input int num_io,
                                   input int io_regs, input int c);
        return (1 << addr_w) - ((num_io - c) * io_regs);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_controller_if.sv
// ============================================================================
//  Module      : bus_controller_if
//  Description : CPU / RAM / IO signal bundle around the bus controller.
//                master : the controller's own view (drives the strobes).
//                slave  : the environment's view (CPU core and peripherals).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_controller_if #(
    parameter int ADDR_W  = 8,
    parameter int NUM_IO  = 2,
    parameter int IO_REGS = 4
);
    logic                       cpuReq;
    logic                       cpuWrite;
    logic [ADDR_W-1:0]          cpuAddr;
    logic                       cpuReady;
    logic                       cpuFault;
    logic                       memReadEnable;
    logic                       memWriteEnable;
    logic [NUM_IO-1:0]          ioReadEnable;
    logic [NUM_IO-1:0]          ioWriteEnable;
    logic [NUM_IO-1:0]          ioReady;
    logic [$clog2(IO_REGS)-1:0] regSelect;

    modport master (
        input  cpuReq, cpuWrite, cpuAddr, ioReady,
        output cpuReady, cpuFault, memReadEnable, memWriteEnable,
               ioReadEnable, ioWriteEnable, regSelect
    );

    modport slave (
        output cpuReq, cpuWrite, cpuAddr, ioReady,
        input  cpuReady, cpuFault, memReadEnable, memWriteEnable,
               ioReadEnable, ioWriteEnable, regSelect
    );
endinterface

`default_nettype wire

// File: rtl/bus_addr_decode.sv
// ============================================================================
//  Module      : bus_addr_decode
//  Description : Combinational CPU address to access target decoder. IO
//                channels sit at the top of the address space, everything
//                else is main memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int NUM_IO  = 2,
    parameter int IO_REGS = 4
) (
    input  wire logic [ADDR_W-1:0] i_addr,
    output target_t                o_target
);

    localparam int c_RS_W = $clog2(IO_REGS);

    logic [NUM_IO-1:0] w_hit;

    // Channel bases are IO_REGS-aligned, so matching the upper bits suffices.
    generate
        for (genvar c = 0; c < NUM_IO; c++) begin : g_ch
            localparam logic [ADDR_W-1:0] c_BASE =
                ADDR_W'(io_base(ADDR_W, NUM_IO, IO_REGS, c));
            assign w_hit[c] = (i_addr[ADDR_W-1:c_RS_W] == c_BASE[ADDR_W-1:c_RS_W]);
        end
    endgenerate

    // Collapse the channel hits into a target; no hit means memory.
    always_comb begin
        o_target = '0;
        for (int c = 0; c < NUM_IO; c++) begin
            if (w_hit[c]) begin
                o_target.isIo    = 1'b1;
                o_target.channel = 3'(c);
                o_target.regSel  = 8'(i_addr[c_RS_W-1:0]);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_controller.sv
// ============================================================================
//  Module      : bus_controller
//  Description : CPU-side bus controller. Decodes each access to RAM or one
//                of NUM_IO IO channels, applies per-target wait states and
//                the IO ready handshake, and returns a cpuReady strobe.
//                Optional macro BUS_TIMEOUT_EN adds an IO ready timeout that
//                ends the access with cpuFault.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_controller
    import bus_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int NUM_IO         = 2,
    parameter int IO_REGS        = 4,
    parameter int MEM_WAIT       = 0,
    parameter int IO_WAIT        = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input wire logic         clk,
    input wire logic         rst_n,
    bus_controller_if.master bus
);

    localparam int c_RS_W = $clog2(IO_REGS);
    localparam int c_CH_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;

    target_t           w_tgt;
    bus_state_t        r_state;
    logic              r_isIo;
    logic              r_write;
    logic [c_CH_W-1:0] r_ch;
    logic [c_RS_W-1:0] r_regSel;
    logic [3:0]        r_wait;
    logic              w_access;
    logic              w_selRdy;
    logic              w_normal;
    logic              w_timeout;
    logic              w_done;
    logic              w_fault;
    logic [NUM_IO-1:0] w_chOneHot;
    logic              w_unused;

    bus_addr_decode #(
        .ADDR_W  (ADDR_W),
        .NUM_IO  (NUM_IO),
        .IO_REGS (IO_REGS)
    ) u_decode (
        .i_addr   (bus.cpuAddr),
        .o_target (w_tgt)
    );

    // Struct fields are sized for the widest configuration; spare bits unused.
    assign w_unused = ^w_tgt;

    assign w_access   = (r_state == ACCESS);
    assign w_selRdy   = bus.ioReady[r_ch];
    assign w_chOneHot = NUM_IO'(1) << r_ch;
    // Regular completion once the wait states are spent (and the IO is ready).
    assign w_normal   = w_access && (r_wait == 4'd0) && (!r_isIo || w_selRdy);

`ifdef BUS_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TMO_W-1:0] r_tmo;

    // Counts ACCESS cycles of the current IO access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tmo <= '0;
        else if (r_state == IDLE)
            r_tmo <= '0;
        else if (w_access && !w_done)
            r_tmo <= r_tmo + 1'b1;
    end

    assign w_timeout = w_access && r_isIo && (r_tmo == c_TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // A ready IO in the timeout cycle wins: the access completes normally.
    assign w_done  = w_normal || w_timeout;
    assign w_fault = w_timeout && !w_normal;

    // Sequencer: accept in IDLE, count waits in ACCESS, one turnaround cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_isIo   <= 1'b0;
            r_write  <= 1'b0;
            r_ch     <= '0;
            r_regSel <= '0;
            r_wait   <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cpuReq) begin
                        r_isIo   <= w_tgt.isIo;
                        r_write  <= bus.cpuWrite;
                        r_ch     <= c_CH_W'(w_tgt.channel);
                        r_regSel <= c_RS_W'(w_tgt.regSel);
                        r_wait   <= w_tgt.isIo ? 4'(IO_WAIT) : 4'(MEM_WAIT);
                        r_state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (w_done)
                        r_state <= DONE;
                    else if (r_wait != 4'd0)
                        r_wait <= r_wait - 4'd1;
                end
                DONE: begin
                    r_regSel <= '0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Strobes decode from registered state; ioReady is the only live input
    // because the IO completes in the cycle its device signals ready.
    assign bus.cpuReady       = w_done;
    assign bus.cpuFault       = w_fault;
    assign bus.memReadEnable  = w_access && !r_isIo;
    assign bus.memWriteEnable = w_access && !r_isIo && r_write && w_done;
    assign bus.ioReadEnable   = (w_access && r_isIo) ? w_chOneHot : '0;
    assign bus.ioWriteEnable  = (w_access && r_isIo && r_write && w_normal) ? w_chOneHot : '0;
    assign bus.regSelect      = r_regSel;

endmodule

`default_nettype wire

// File: tb/tb_bus_controller.sv
// ============================================================================
//  Module      : tb_bus_controller
//  Description : Directed self-checking bench for bus_controller. Instance A
//                uses default parameters, instance B uses MEM_WAIT=3.
//                Timeout scenario is built when BUS_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_controller;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bus_controller_if bus_a ();
    bus_controller_if bus_b ();

    bus_controller #(.MEM_WAIT(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    bus_controller #(.MEM_WAIT(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs_a();
        return 32'({bus_a.cpuReady, bus_a.cpuFault, bus_a.memReadEnable, bus_a.memWriteEnable,
                    bus_a.ioReadEnable, bus_a.ioWriteEnable, bus_a.regSelect});
    endfunction

    function automatic logic [31:0] outs_b();
        return 32'({bus_b.cpuReady, bus_b.cpuFault, bus_b.memReadEnable, bus_b.memWriteEnable,
                    bus_b.ioReadEnable, bus_b.ioWriteEnable, bus_b.regSelect});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.cpuReq = 1'b0; bus_a.cpuWrite = 1'b0; bus_a.cpuAddr = 8'h00; bus_a.ioReady = 2'b00;
        bus_b.cpuReq = 1'b0; bus_b.cpuWrite = 1'b0; bus_b.cpuAddr = 8'h00; bus_b.ioReady = 2'b00;

        // Reset state
        #12;
        chk("rst_outs_a", outs_a(), 32'h0);
        chk("rst_outs_b", outs_b(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Memory read at 0x10, MEM_WAIT=0
        tick();
        bus_a.cpuReq = 1'b1; bus_a.cpuWrite = 1'b0; bus_a.cpuAddr = 8'h10;
        #1;
        chk("mem_rd_c0_memrd", 32'(bus_a.memReadEnable), 32'h0);
        tick(); #1;
        chk("mem_rd_c1_memrd", 32'(bus_a.memReadEnable), 32'h1);
        chk("mem_rd_c1_ready", 32'(bus_a.cpuReady), 32'h1);
        chk("mem_rd_c1_iord", 32'(bus_a.ioReadEnable), 32'h0);
        chk("mem_rd_c1_memwr", 32'(bus_a.memWriteEnable), 32'h0);
        tick();
        bus_a.cpuReq = 1'b0;
        #1;
        chk("mem_rd_c2_done", outs_a(), 32'h0);

        // IO write to 0xFD, ioReady[1] held high
        tick();
        bus_a.cpuReq = 1'b1; bus_a.cpuWrite = 1'b1; bus_a.cpuAddr = 8'hFD; bus_a.ioReady = 2'b10;
        #1;
        tick(); #1;
        chk("io_wr_c1_iord", 32'(bus_a.ioReadEnable), 32'h2);
        chk("io_wr_c1_iowr", 32'(bus_a.ioWriteEnable), 32'h0);
        chk("io_wr_c1_ready", 32'(bus_a.cpuReady), 32'h0);
        chk("io_wr_c1_regsel", 32'(bus_a.regSelect), 32'h1);
        tick(); #1;
        chk("io_wr_c2_iord", 32'(bus_a.ioReadEnable), 32'h2);
        chk("io_wr_c2_iowr", 32'(bus_a.ioWriteEnable), 32'h2);
        chk("io_wr_c2_ready", 32'(bus_a.cpuReady), 32'h1);
        chk("io_wr_c2_fault", 32'(bus_a.cpuFault), 32'h0);
        chk("io_wr_c2_memrd", 32'(bus_a.memReadEnable), 32'h0);
        tick();
        bus_a.cpuReq = 1'b0; bus_a.ioReady = 2'b00;
        #1;
        chk("io_wr_c3_done", outs_a(), 32'h1);
        tick(); #1;
        chk("io_wr_c4_idle", outs_a(), 32'h0);

        // IO read at 0xF9; channel 1 ready is ignored; ioReady[0] rises in cycle 5
        bus_a.cpuReq = 1'b1; bus_a.cpuWrite = 1'b0; bus_a.cpuAddr = 8'hF9; bus_a.ioReady = 2'b10;
        #1;
        for (int k = 1; k <= 4; k++) begin
            tick(); #1;
            chk("io_rd_wait_ready", 32'(bus_a.cpuReady), 32'h0);
            chk("io_rd_wait_iord", 32'(bus_a.ioReadEnable), 32'h1);
        end
        tick();
        bus_a.ioReady = 2'b11;
        #1;
        chk("io_rd_c5_ready", 32'(bus_a.cpuReady), 32'h1);
        chk("io_rd_c5_regsel", 32'(bus_a.regSelect), 32'h1);
        chk("io_rd_c5_iord", 32'(bus_a.ioReadEnable), 32'h1);
        chk("io_rd_c5_iowr", 32'(bus_a.ioWriteEnable), 32'h0);
        tick();
        bus_a.cpuReq = 1'b0; bus_a.ioReady = 2'b00;
        #1;
        chk("io_rd_c6_ready", 32'(bus_a.cpuReady), 32'h0);
        tick(); #1;

        // IO write to 0xFF with ioReady never high
        bus_a.cpuReq = 1'b1; bus_a.cpuWrite = 1'b1; bus_a.cpuAddr = 8'hFF; bus_a.ioReady = 2'b00;
        #1;
`ifdef BUS_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            tick(); #1;
            chk("tmo_wait_ready", 32'(bus_a.cpuReady), 32'h0);
            chk("tmo_wait_iowr", 32'(bus_a.ioWriteEnable), 32'h0);
        end
        tick(); #1;
        chk("tmo_c16_ready", 32'(bus_a.cpuReady), 32'h1);
        chk("tmo_c16_fault", 32'(bus_a.cpuFault), 32'h1);
        chk("tmo_c16_iowr", 32'(bus_a.ioWriteEnable), 32'h0);
        chk("tmo_c16_iord", 32'(bus_a.ioReadEnable), 32'h2);
`else
        for (int k = 1; k <= 20; k++) begin
            tick(); #1;
            chk("notmo_wait_ready", 32'(bus_a.cpuReady), 32'h0);
            chk("notmo_wait_fault", 32'(bus_a.cpuFault), 32'h0);
        end
        tick();
        bus_a.ioReady = 2'b10;
        #1;
        chk("notmo_end_ready", 32'(bus_a.cpuReady), 32'h1);
        chk("notmo_end_fault", 32'(bus_a.cpuFault), 32'h0);
        chk("notmo_end_iowr", 32'(bus_a.ioWriteEnable), 32'h2);
`endif
        tick();
        bus_a.cpuReq = 1'b0; bus_a.ioReady = 2'b00;
        #1;
        chk("w_ff_done", outs_a(), 32'h3);
        tick(); #1;

        // Back-to-back: 0xF7 (memory) then 0xF8 (channel 0, reg 0)
        bus_a.cpuReq = 1'b1; bus_a.cpuWrite = 1'b0; bus_a.cpuAddr = 8'hF7;
        #1;
        tick(); #1;
        chk("b2b_c1_memrd", 32'(bus_a.memReadEnable), 32'h1);
        chk("b2b_c1_ready", 32'(bus_a.cpuReady), 32'h1);
        chk("b2b_c1_iord", 32'(bus_a.ioReadEnable), 32'h0);
        tick();
        bus_a.cpuAddr = 8'hF8;
        #1;
        chk("b2b_c2_done", outs_a(), 32'h0);
        tick(); #1;
        chk("b2b_c3_idle", outs_a(), 32'h0);
        tick(); #1;
        chk("b2b_c4_iord", 32'(bus_a.ioReadEnable), 32'h1);
        chk("b2b_c4_memrd", 32'(bus_a.memReadEnable), 32'h0);
        chk("b2b_c4_regsel", 32'(bus_a.regSelect), 32'h0);
        chk("b2b_c4_ready", 32'(bus_a.cpuReady), 32'h0);
        tick();
        bus_a.ioReady = 2'b01;
        #1;
        chk("b2b_c5_ready", 32'(bus_a.cpuReady), 32'h1);
        tick();
        bus_a.cpuReq = 1'b0; bus_a.ioReady = 2'b00;
        #1;

        // Reset mid-access on instance B (MEM_WAIT=3)
        tick();
        bus_b.cpuReq = 1'b1; bus_b.cpuWrite = 1'b1; bus_b.cpuAddr = 8'h40;
        #1;
        tick(); #1;
        chk("rstmid_c1_memrd", 32'(bus_b.memReadEnable), 32'h1);
        chk("rstmid_c1_memwr", 32'(bus_b.memWriteEnable), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_outs_b", outs_b(), 32'h0);
        tick();
        bus_b.cpuReq = 1'b0;
        #1;
        chk("rstmid_hold_b", outs_b(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus_b.cpuReq = 1'b1; bus_b.cpuWrite = 1'b0; bus_b.cpuAddr = 8'h20;
        #1;
        for (int k = 1; k <= 3; k++) begin
            tick(); #1;
            chk("rstmid_new_memrd", 32'(bus_b.memReadEnable), 32'h1);
            chk("rstmid_new_ready", 32'(bus_b.cpuReady), 32'h0);
        end
        tick(); #1;
        chk("rstmid_new_c4_ready", 32'(bus_b.cpuReady), 32'h1);
        chk("rstmid_new_c4_memrd", 32'(bus_b.memReadEnable), 32'h1);
        chk("rstmid_new_c4_memwr", 32'(bus_b.memWriteEnable), 32'h0);
        tick();
        bus_b.cpuReq = 1'b0;
        #1;
        chk("rstmid_new_done", outs_b(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
